// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Shift-mode encodings, the burst FSM state type and the mode field type.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'd0;
    localparam mode_t MODE_SHL  = 3'd1;
    localparam mode_t MODE_SHR  = 3'd2;
    localparam mode_t MODE_ROL  = 3'd3;
    localparam mode_t MODE_ROR  = 3'd4;
    localparam mode_t MODE_ASR  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control/data bundle for universal_shift_reg.
// master: drives sset, enable, load, data, mode, shiftin, start and count;
//         observes q, shiftout, busy and done.
// slave : the register itself, the mirror image of master.
interface universal_shift_reg_if #(
    parameter int unsigned SHIFT_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = 4
);
    import usr_pkg::*;

    logic                   sset;
    logic                   enable;
    logic                   load;
    logic [SHIFT_WIDTH-1:0] data;
    mode_t                  mode;
    logic                   shiftin;
    logic                   start;
    logic [CNT_WIDTH-1:0]   count;
    logic [SHIFT_WIDTH-1:0] q;
    logic                   shiftout;
    logic                   busy;
    logic                   done;

    modport master (
        output sset, enable, load, data, mode, shiftin, start, count,
        input  q, shiftout, busy, done
    );

    modport slave (
        input  sset, enable, load, data, mode, shiftin, start, count,
        output q, shiftout, busy, done
    );

endinterface

// File: rtl/usr_shift_step.sv
// One shift step: combinational next register value and next shift-out bit.
// Ports:
//   q_i        current register contents
//   shiftout_i current shift-out bit (kept for HOLD and the unused modes)
//   mode_i     shift mode
//   shiftin_i  serial input for SHL/SHR
//   q_o        register contents after the step
//   shiftout_o bit expelled by the step
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] q_i,
    input  logic             shiftout_i,
    input  mode_t            mode_i,
    input  logic             shiftin_i,
    output logic [Width-1:0] q_o,
    output logic             shiftout_o
);

    always_comb begin
        q_o        = q_i;
        shiftout_o = shiftout_i;
        case (mode_i)
            MODE_SHL: begin
                q_o        = {q_i[Width-2:0], shiftin_i};
                shiftout_o = q_i[Width-1];
            end
            MODE_SHR: begin
                q_o        = {shiftin_i, q_i[Width-1:1]};
                shiftout_o = q_i[0];
            end
            MODE_ROL: begin
                q_o        = {q_i[Width-2:0], q_i[Width-1]};
                shiftout_o = q_i[Width-1];
            end
            MODE_ROR: begin
                q_o        = {q_i[0], q_i[Width-1:1]};
                shiftout_o = q_i[0];
            end
            MODE_ASR: begin
                q_o        = {q_i[Width-1], q_i[Width-1:1]};
                shiftout_o = q_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with runtime shift modes and a burst engine.
// Ports:
//   clock  rising-edge clock
//   sclr   synchronous active-high clear, overrides everything
//   bus    universal_shift_reg_if slave: sset/enable/load/data/mode/shiftin/
//          start/count in, q/shiftout/busy/done out
// In IDLE each enabled edge performs one shift with the live mode. A start
// latches mode and count and runs count shifts autonomously, then pulses done.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned SHIFT_WIDTH = 8,
    parameter int unsigned LOAD_SVALUE = 4,
    parameter int unsigned CNT_WIDTH   = 4
) (
    input logic                  clock,
    input logic                  sclr,
    universal_shift_reg_if.slave bus
);

    localparam logic [SHIFT_WIDTH-1:0] LoadVal = SHIFT_WIDTH'(LOAD_SVALUE);
    localparam logic [CNT_WIDTH-1:0]   CntOne  = CNT_WIDTH'(1);

    state_e                 state_q;
    mode_t                  mode_q;
    logic [CNT_WIDTH-1:0]   rem_q;
    logic [SHIFT_WIDTH-1:0] q_q;
    logic                   shiftout_q;
    logic                   busy_q;
    logic                   done_q;

    mode_t                  step_mode;
    logic [SHIFT_WIDTH-1:0] step_q;
    logic                   step_so;

    // A running burst ignores the live mode and uses the one latched at start.
    assign step_mode = (state_q == ST_RUN) ? mode_q : bus.mode;

    usr_shift_step #(
        .Width (SHIFT_WIDTH)
    ) u_step (
        .q_i        (q_q),
        .shiftout_i (shiftout_q),
        .mode_i     (step_mode),
        .shiftin_i  (bus.shiftin),
        .q_o        (step_q),
        .shiftout_o (step_so)
    );

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_HOLD;
            rem_q      <= '0;
            q_q        <= '0;
            shiftout_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (!bus.enable) begin
            // Everything holds; done is a strict single-cycle pulse.
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.sset) begin
                        q_q <= LoadVal;
                    end else if (bus.load) begin
                        q_q <= bus.data;
                    end else if (bus.start) begin
                        mode_q <= bus.mode;
                        rem_q  <= bus.count;
                        if (bus.count != '0) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else begin
                        q_q        <= step_q;
                        shiftout_q <= step_so;
                    end
                end
                ST_RUN: begin
                    if (bus.sset) begin
                        // Abort: no done pulse for an interrupted burst.
                        q_q     <= LoadVal;
                        rem_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        q_q        <= step_q;
                        shiftout_q <= step_so;
                        rem_q      <= rem_q - CntOne;
                        if (rem_q == CntOne) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.q        = q_q;
    assign bus.shiftout = shiftout_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
